// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: sequences load, per-iteration X/Y/Z add/sub handshakes and the final
// sign-corrected result for an iterative CORDIC datapath. Optional macro: CORDIC_SEQ_TIMEOUT_EN.
`default_nettype none

module cordic_seq_ctrl #(
    parameter int ITERS   = 24,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
    input  logic             op,
    input  logic             vec_mode,
    input  logic [1:0]       quad,
    input  logic             add_ready,
    output logic             add_start,
    output logic             add_ack,
    output logic [1:0]       var_sel,
    output logic [CNT_W-1:0] iter,
    output logic             first_iter,
    output logic             dir_src,
    output logic             en_in,
    output logic             en_stage,
    output logic             en_shift,
    output logic             en_x,
    output logic             en_y,
    output logic             en_z,
    output logic             en_final,
    output logic             en_out,
    output logic             out_sel,
    output logic             busy,
    output logic             ready,
    output logic             err
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LOAD  = 4'd1;
    localparam logic [3:0] S_SETUP = 4'd2;
    localparam logic [3:0] S_SHIFT = 4'd3;
    localparam logic [3:0] S_REQ   = 4'd4;
    localparam logic [3:0] S_WAIT  = 4'd5;
    localparam logic [3:0] S_FREQ  = 4'd6;
    localparam logic [3:0] S_FWAIT = 4'd7;
    localparam logic [3:0] S_OUT   = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(ITERS - 1);

    // Parameters outside their legal range leave this empty marker block in the hierarchy.
    if (ITERS < 1 || ITERS > 255 || TIMEOUT < 1) begin : g_param_range_violation
    end

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_iter;
    logic [1:0]       r_var;
    logic             r_op;
    logic             r_vec;
    logic [1:0]       r_quad;

    logic             w_swap;
    logic [1:0]       w_final_sel;
    logic             w_in_wait;
    logic             w_tmo;
    logic             w_take;

    assign w_swap      = (r_quad == 2'b01) || (r_quad == 2'b10);
    assign w_final_sel = ((~r_op) ^ w_swap) ? 2'b00 : 2'b01;
    assign w_in_wait   = (r_state == S_WAIT) || (r_state == S_FWAIT);

`ifdef CORDIC_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_tcnt;
    logic          r_err;

    // Expires on the TIMEOUT-th consecutive wait cycle without add_ready.
    assign w_tmo = w_in_wait && !add_ready && (r_tcnt == C_TMO_LAST);
    assign err   = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_REQ || r_state == S_FREQ)
                r_tcnt <= '0;
            else if (w_in_wait && !add_ready && !w_tmo)
                r_tcnt <= r_tcnt + 1'b1;
            if (r_state == S_IDLE && start)
                r_err <= 1'b0;
            else if (w_tmo)
                r_err <= 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    assign w_take = w_in_wait && (add_ready || w_tmo);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_var   <= 2'b00;
            r_op    <= 1'b0;
            r_vec   <= 1'b0;
            r_quad  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_op    <= op;
                        r_vec   <= vec_mode;
                        r_quad  <= quad;
                        r_iter  <= '0;
                    end
                end
                S_LOAD:  r_state <= S_SETUP;
                S_SETUP: r_state <= S_SHIFT;
                S_SHIFT: begin
                    r_state <= S_REQ;
                    r_var   <= 2'b00;
                end
                S_REQ:   r_state <= S_WAIT;
                S_WAIT: begin
                    if (add_ready) begin
                        if (r_var != 2'b10) begin
                            r_var   <= r_var + 2'b01;
                            r_state <= S_REQ;
                        end else if (r_iter == C_LAST_ITER) begin
                            r_state <= S_FREQ;
                        end else begin
                            r_iter  <= r_iter + 1'b1;
                            r_state <= S_SETUP;
                        end
                    end else if (w_tmo) begin
                        r_state <= S_DONE;
                    end
                end
                S_FREQ:  r_state <= S_FWAIT;
                S_FWAIT: begin
                    if (add_ready)
                        r_state <= S_OUT;
                    else if (w_tmo)
                        r_state <= S_DONE;
                end
                S_OUT:   r_state <= S_DONE;
                S_DONE: begin
                    if (ack)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign add_start  = (r_state == S_REQ) || (r_state == S_FREQ);
    assign add_ack    = w_take;
    assign var_sel    = (r_state == S_REQ  || r_state == S_WAIT)  ? r_var :
                        (r_state == S_FREQ || r_state == S_FWAIT) ? w_final_sel : 2'b00;
    assign iter       = r_iter;
    assign busy       = (r_state != S_IDLE);
    assign first_iter = busy && (r_iter == '0);
    assign dir_src    = r_vec;
    assign en_in      = (r_state == S_LOAD);
    assign en_stage   = (r_state == S_SETUP);
    assign en_shift   = (r_state == S_SHIFT);
    assign en_x       = (r_state == S_WAIT) && add_ready && (r_var == 2'b00);
    assign en_y       = (r_state == S_WAIT) && add_ready && (r_var == 2'b01);
    assign en_z       = (r_state == S_WAIT) && add_ready && (r_var == 2'b10);
    assign en_final   = (r_state == S_FWAIT) && add_ready;
    assign en_out     = (r_state == S_OUT);
    assign out_sel    = (r_state == S_OUT) && w_swap;
    assign ready      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: ITERS=4 instance with a 1-cycle add/sub responder and
// an ITERS=1 instance with a 3-cycle responder.
`default_nettype none

module tb_cordic_seq_ctrl;

    logic clk = 1'b0;
    logic reset, ack, op, vec_mode;
    logic [1:0] quad;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // ---------------- DUT 0: ITERS = 4, W = 1 ----------------
    logic start0, add_ready0, resp_en0;
    logic add_start0, add_ack0, first_iter0, dir_src0;
    logic [1:0] var_sel0;
    logic [7:0] iter0;
    logic en_in0, en_stage0, en_shift0, en_x0, en_y0, en_z0, en_final0, en_out0;
    logic out_sel0, busy0, ready0, err0;
    int dly0 = 0;

    cordic_seq_ctrl #(.ITERS(4), .CNT_W(8), .TIMEOUT(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .ack(ack), .op(op), .vec_mode(vec_mode),
        .quad(quad), .add_ready(add_ready0), .add_start(add_start0), .add_ack(add_ack0),
        .var_sel(var_sel0), .iter(iter0), .first_iter(first_iter0), .dir_src(dir_src0),
        .en_in(en_in0), .en_stage(en_stage0), .en_shift(en_shift0), .en_x(en_x0),
        .en_y(en_y0), .en_z(en_z0), .en_final(en_final0), .en_out(en_out0),
        .out_sel(out_sel0), .busy(busy0), .ready(ready0), .err(err0)
    );

    always @(posedge clk) begin
        if (add_start0) dly0 <= 1;
        else if (dly0 != 0) dly0 <= dly0 - 1;
    end
    assign add_ready0 = resp_en0 && (dly0 == 1);

    wire [25:0] outs0 = {add_start0, add_ack0, var_sel0, iter0, first_iter0, dir_src0,
                         en_in0, en_stage0, en_shift0, en_x0, en_y0, en_z0, en_final0,
                         en_out0, out_sel0, busy0, ready0, err0};

    // ---------------- DUT 1: ITERS = 1, W = 3 ----------------
    logic start1, add_ready1;
    logic add_start1, add_ack1, first_iter1, dir_src1;
    logic [1:0] var_sel1;
    logic [7:0] iter1;
    logic en_in1, en_stage1, en_shift1, en_x1, en_y1, en_z1, en_final1, en_out1;
    logic out_sel1, busy1, ready1, err1;
    int dly1 = 0;

    cordic_seq_ctrl #(.ITERS(1), .CNT_W(8), .TIMEOUT(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .ack(ack), .op(op), .vec_mode(vec_mode),
        .quad(quad), .add_ready(add_ready1), .add_start(add_start1), .add_ack(add_ack1),
        .var_sel(var_sel1), .iter(iter1), .first_iter(first_iter1), .dir_src(dir_src1),
        .en_in(en_in1), .en_stage(en_stage1), .en_shift(en_shift1), .en_x(en_x1),
        .en_y(en_y1), .en_z(en_z1), .en_final(en_final1), .en_out(en_out1),
        .out_sel(out_sel1), .busy(busy1), .ready(ready1), .err(err1)
    );

    always @(posedge clk) begin
        if (add_start1) dly1 <= 3;
        else if (dly1 != 0) dly1 <= dly1 - 1;
    end
    assign add_ready1 = (dly1 == 1);

    wire [25:0] outs1 = {add_start1, add_ack1, var_sel1, iter1, first_iter1, dir_src1,
                         en_in1, en_stage1, en_shift1, en_x1, en_y1, en_z1, en_final1,
                         en_out1, out_sel1, busy1, ready1, err1};

    // Monitor of DUT 0: X,Y,Z update order, final operand select and result sign select.
    int pcount = 0;
    int seq_bad = 0;
    logic [1:0] fvar = 2'b11;
    logic osel = 1'b0;
    always @(negedge clk) begin
        if (en_x0 || en_y0 || en_z0) begin
            if ({en_z0, en_y0, en_x0} !== (3'b001 << (pcount % 3))) seq_bad++;
            pcount++;
        end
        if (en_final0) fvar = var_sel0;
        if (en_out0) osel = out_sel0;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts an operation on DUT 0 and counts cycles from the accept edge until ready is seen.
    task automatic run0(input logic o, input logic v, input logic [1:0] q, input bit hold,
                        output int lat);
        @(negedge clk);
        op = o; vec_mode = v; quad = q; start0 = 1'b1;
        @(posedge clk);
        #1;
        pcount = 0; seq_bad = 0; fvar = 2'b11; osel = 1'b0;
        if (!hold) start0 = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (ready0) break;
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    int lat;
    int guard;

    initial begin
        reset = 1'b1; ack = 1'b0; op = 1'b0; vec_mode = 1'b0; quad = 2'b00;
        start0 = 1'b0; start1 = 1'b0; resp_en0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs0", outs0, 0);
        chk("reset_outs1", outs1, 0);
        reset = 1'b0;

        // cosine, quad 00, rotation
        run0(1'b0, 1'b0, 2'b00, 1'b0, lat);
        chk("lat_op0_q00", lat, 37);
        chk("pulses_xyz", pcount, 12);
        chk("xyz_order_errs", seq_bad, 0);
        chk("final_sel_op0_q00", fvar, 2'b00);
        chk("out_sel_op0_q00", osel, 0);
        chk("dir_src_rot", dir_src0, 0);
        ack_pulse();
        chk("idle_after_ack", busy0, 0);

        // sine, quad 10, vectoring
        run0(1'b1, 1'b1, 2'b10, 1'b0, lat);
        chk("final_sel_op1_q10", fvar, 2'b00);
        chk("out_sel_op1_q10", osel, 1);
        chk("dir_src_vec", dir_src0, 1);
        ack_pulse();

        // sine, quad 00
        run0(1'b1, 1'b0, 2'b00, 1'b0, lat);
        chk("final_sel_op1_q00", fvar, 2'b01);
        chk("out_sel_op1_q00", osel, 0);
        ack_pulse();

        // reset during the WAIT state of iteration 2
        @(negedge clk);
        op = 1'b0; quad = 2'b00; vec_mode = 1'b0; start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        guard = 0;
        while (!(iter0 == 8'd2 && add_start0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_iter2_req", guard < 500, 1);
        @(negedge clk);
        chk("in_wait_iter2", add_ready0 && !add_start0 && busy0, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_outs0", outs0, 0);
        @(negedge clk);
        chk("abort_quiet", {add_start0, add_ack0, busy0}, 0);
        run0(1'b0, 1'b0, 2'b00, 1'b0, lat);
        chk("lat_after_abort", lat, 37);
        chk("pulses_after_abort", pcount, 12);
        ack_pulse();

        // start held high throughout; ack in the first DONE cycle
        run0(1'b0, 1'b0, 2'b00, 1'b1, lat);
        chk("lat_start_held", lat, 37);
        ack_pulse();
        chk("idle_one_cycle", busy0, 0);
        @(negedge clk);
        chk("restart_load", {busy0, en_in0}, 2'b11);
        start0 = 1'b0;
        guard = 0;
        while (!ready0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("second_op_done", ready0, 1);
        ack_pulse();

        // single-iteration instance with W = 3
        @(negedge clk);
        op = 1'b0; quad = 2'b00; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == 2) chk("first_iter_setup", {en_stage1, first_iter1}, 2'b11);
            if (ready1) break;
        end
        chk("lat_iters1_w3", lat, 21);
        ack_pulse();

`ifdef CORDIC_SEQ_TIMEOUT_EN
        // add_ready never arrives: 8 WAIT cycles then DONE with err
        resp_en0 = 1'b0;
        run0(1'b0, 1'b0, 2'b00, 1'b0, lat);
        chk("lat_timeout", lat, 13);
        chk("err_timeout", err0, 1);
        ack_pulse();
        chk("err_holds_idle", err0, 1);
        resp_en0 = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("err_cleared", err0, 0);
        guard = 0;
        while (!ready0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        ack_pulse();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cordic_seq_ctrl.md
CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

Interface
REQ-001 Parameter ITERS, default 24: CORDIC iterations per operation; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the iteration counter; SHALL be >= clog2(ITERS).
REQ-003 Parameter TIMEOUT, default 255: maximum add/sub wait cycles; used only with the timeout feature.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request a new operation; sampled only in IDLE.
REQ-007 ack  in  1  consumer has taken the result.
REQ-008 op  in  1  operation select: 0 = cosine, 1 = sine.
REQ-009 vec_mode  in  1  0 = rotation, 1 = vectoring.
REQ-010 quad  in  2  angle-region flag from the range reducer.
REQ-011 add_ready  in  1  add/sub unit result valid.
REQ-012 add_start  out  1  one-cycle add/sub start pulse.
REQ-013 add_ack  out  1  one-cycle add/sub result acknowledge.
REQ-014 var_sel  out  2  operand select: 00 = X, 01 = Y, 10 = Z.
REQ-015 iter  out  CNT_W  current iteration index, used for shift amount and LUT address.
REQ-016 first_iter  out  1  high when iter == 0; selects the initial operand path.
REQ-017 dir_src  out  1  direction-sign source: 0 = sign of Z, 1 = sign of Y.
REQ-018 en_in, en_stage, en_shift, en_x, en_y, en_z, en_final, en_out  out  1 each  register enables.
REQ-019 out_sel  out  1  result sign-invert select.
REQ-020 busy, ready, err  out  1 each  status outputs.

Function
REQ-021 In IDLE, start == 1 SHALL move the block to LOAD, latch op, vec_mode and quad, clear iter and clear err; start SHALL be ignored in every other state.
REQ-022 LOAD SHALL last 1 cycle with en_in = 1; it SHALL then move to SETUP.
REQ-023 SETUP SHALL last 1 cycle with en_stage = 1; SHIFT SHALL then last 1 cycle with en_shift = 1.
REQ-024 For each variable X, Y, then Z, the block SHALL spend 1 cycle in REQ with add_start = 1 and var_sel held, then stay in WAIT with var_sel held until add_ready == 1.
REQ-025 In the WAIT cycle where add_ready == 1, the block SHALL pulse the matching en_x, en_y or en_z together with add_ack, then continue to the next variable.
REQ-026 add_ready SHALL be ignored outside the WAIT states.
REQ-027 After Z: if iter < ITERS-1, the block SHALL increment iter and go to SETUP; otherwise it SHALL go to FREQ.
REQ-028 FREQ and FWAIT SHALL follow the same handshake as REQ-024/025, but pulse en_final instead of en_x/en_y/en_z.
REQ-029 Final var_sel SHALL be X when (op == 0) XOR swap, and Y otherwise, where swap = (quad == 01 or quad == 10).
REQ-030 OUT SHALL last 1 cycle with en_out = 1 and out_sel = swap; the block SHALL then go to DONE.
REQ-031 In DONE, ready SHALL be 1; on ack the block SHALL return to IDLE on the next edge, including when ack arrives in the first DONE cycle.
REQ-032 dir_src SHALL equal the latched vec_mode.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 With W = WAIT cycles per handshake (W >= 1), ready SHALL first be high ITERS*(3W+5)+W+4 cycles after the start-accept edge.
REQ-035 When ITERS == 1, the single iteration SHALL be both first and last.

Reset
REQ-036 While reset is high at a rising edge, the block SHALL go to IDLE and clear iter, latched fields, the timeout counter and err; all outputs SHALL be 0 from the next cycle.
REQ-037 Reset asserted mid-operation SHALL abort the operation without issuing further add_start or add_ack pulses.

Configuration
REQ-038 Macro CORDIC_SEQ_TIMEOUT_EN defined: a wait counter SHALL run in WAIT/FWAIT and clear on each REQ/FREQ.
REQ-039 With CORDIC_SEQ_TIMEOUT_EN defined, if the counter reaches TIMEOUT without add_ready, the block SHALL pulse add_ack, set err = 1 and go to DONE; err SHALL stay set until the next accepted start or reset.
REQ-040 Macro CORDIC_SEQ_TIMEOUT_EN undefined: the block SHALL wait indefinitely in WAIT states, err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-041 ITERS = 4, add_ready 1 cycle after each add_start (W = 1), op = 0, quad = 00 -> ready first high 37 cycles after start; 12 en_x/en_y/en_z pulses in X, Y, Z order; final var_sel = X; out_sel = 0.
REQ-042 op = 1, quad = 10 -> final var_sel = X, out_sel = 1; op = 1, quad = 00 -> final var_sel = Y, out_sel = 0.
REQ-043 Reset pulsed during the WAIT state of iteration 2 -> IDLE next cycle, all outputs 0; a new start then completes normally.
REQ-044 start held high through DONE, ack in the first DONE cycle -> IDLE for 1 cycle, then a second operation begins; no start accepted while busy.
REQ-045 CORDIC_SEQ_TIMEOUT_EN defined, TIMEOUT = 8, add_ready never asserted -> err = 1 and ready = 1 after 8 WAIT cycles; the next start clears err.
REQ-046 ITERS = 1, W = 3 -> first_iter high in SETUP; ready after 1*(14)+3+4 = 21 cycles.
